// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between WB and a multi-cycle unit.
// Also keeps a pending-write scoreboard for decode hazard checks.
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic            mc_valid,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  output logic            mc_ready,
  input  logic            mc_issue,
  input  logic [4:0]      mc_issue_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      r_starve_cnt;
  logic [31:0]     r_busy;
  logic            r_we;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_data;

  logic            w_forced;
  logic            w_wb_xfer;
  logic            w_mc_xfer;
  logic            w_gnt;
  logic [4:0]      w_gnt_rd;
  logic [XLEN-1:0] w_gnt_data;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_busy_nxt;

  // Forced mode hands the port to the multi-cycle unit for exactly one cycle.
  assign w_forced  = (r_starve_cnt == LP_LIMIT);
  assign wb_ready  = !rst && !w_forced;
  assign mc_ready  = !rst && (w_forced || !wb_valid);
  assign w_wb_xfer = wb_valid && wb_ready;
  assign w_mc_xfer = mc_valid && mc_ready;

  assign w_gnt      = w_wb_xfer || w_mc_xfer;
  assign w_gnt_rd   = w_mc_xfer ? mc_rd : wb_rd;
  assign w_gnt_data = w_mc_xfer ? mc_data : wb_data;

  // Set mask is OR-ed after the clear so a same-cycle issue keeps the bit pending.
  assign w_clr_mask = w_mc_xfer ? (32'd1 << mc_rd) : 32'd0;
  assign w_set_mask = mc_issue ? (32'd1 << mc_issue_rd) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

  assign rs1_busy = r_busy[rs1_addr];
  assign rs2_busy = r_busy[rs2_addr];

  assign rf_we      = r_we;
  assign rf_rd_addr = r_addr;
  assign rf_rd_data = r_data;

  // Write-port register: x0 writes complete the handshake but never assert we.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= 5'd0;
      r_data <= '0;
    end else if (w_gnt) begin
      r_we   <= (w_gnt_rd != 5'd0);
      r_addr <= w_gnt_rd;
      r_data <= w_gnt_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Starvation counter: counts refused multi-cycle cycles, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (!mc_valid || w_mc_xfer) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Pending multi-cycle destination scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (STARVE_LIMIT = 4).
module tb_regfile_write_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic            mc_valid;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            mc_ready;
  logic            mc_issue;
  logic [4:0]      mc_issue_rd;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_we;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h0;
    mc_issue = 1'b0; mc_issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick();
    tick();
    #1;
    chk("rst_wb_ready", {63'd0, wb_ready}, 64'd0);
    chk("rst_mc_ready", {63'd0, mc_ready}, 64'd0);
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_rf_addr", {59'd0, rf_rd_addr}, 64'd0);
    chk("rst_rf_data", {32'd0, rf_rd_data}, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
      chk("rst_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    end

    // Release reset, idle one cycle.
    tick();
    rst = 1'b0; wb_valid = 1'b0; mc_valid = 1'b0;
    tick();

    // WB-only write to x5.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("wb_only_wb_ready", {63'd0, wb_ready}, 64'd1);
    chk("wb_only_mc_ready", {63'd0, mc_ready}, 64'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("wb_only_we", {63'd0, rf_we}, 64'd1);
    chk("wb_only_addr", {59'd0, rf_rd_addr}, 64'd5);
    chk("wb_only_data", {32'd0, rf_rd_data}, 64'hDEADBEEF);
    tick();
    chk("wb_only_we_drop", {63'd0, rf_we}, 64'd0);
    chk("wb_only_addr_hold", {59'd0, rf_rd_addr}, 64'd5);

    // WB write to x0.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h00001234;
    #1;
    chk("wb_x0_ready", {63'd0, wb_ready}, 64'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("wb_x0_we", {63'd0, rf_we}, 64'd0);
    chk("wb_x0_data", {32'd0, rf_rd_data}, 64'h00001234);

    // MC write to x0 together with an issue to x0.
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h00000055;
    mc_issue = 1'b1; mc_issue_rd = 5'd0; rs1_addr = 5'd0;
    #1;
    chk("mc_x0_ready", {63'd0, mc_ready}, 64'd1);
    tick();
    mc_valid = 1'b0; mc_issue = 1'b0;
    #1;
    chk("mc_x0_we", {63'd0, rf_we}, 64'd0);
    chk("mc_x0_busy0", {63'd0, rs1_busy}, 64'd0);

    // MC-only write to x3.
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h0000A5A5;
    tick();
    mc_valid = 1'b0;
    #1;
    chk("mc_only_we", {63'd0, rf_we}, 64'd1);
    chk("mc_only_addr", {59'd0, rf_rd_addr}, 64'd3);
    chk("mc_only_data", {32'd0, rf_rd_data}, 64'h0000A5A5);

    // Contention: four refused cycles then one forced MC cycle, repeating.
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h00000111;
    mc_valid = 1'b1; mc_rd = 5'd2; mc_data = 32'h00000222;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("cont_mc_ready", {63'd0, mc_ready}, (k % 5 == 4) ? 64'd1 : 64'd0);
      chk("cont_wb_ready", {63'd0, wb_ready}, (k % 5 == 4) ? 64'd0 : 64'd1);
      if (k > 0) begin
        chk("cont_we", {63'd0, rf_we}, 64'd1);
        chk("cont_addr", {59'd0, rf_rd_addr}, ((k - 1) % 5 == 4) ? 64'd2 : 64'd1);
      end
      @(posedge clk);
      #1;
    end
    wb_valid = 1'b0; mc_valid = 1'b0;
    tick();

    // Scoreboard: issue x7, complete at cycle 3.
    mc_issue = 1'b1; mc_issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd9;
    #1;
    chk("sb_c0_no_bypass", {63'd0, rs1_busy}, 64'd0);
    tick();
    mc_issue = 1'b0;
    #1;
    chk("sb_c1_busy", {63'd0, rs1_busy}, 64'd1);
    tick();
    chk("sb_c2_busy", {63'd0, rs1_busy}, 64'd1);
    tick();
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h00000777;
    #1;
    chk("sb_c3_ready", {63'd0, mc_ready}, 64'd1);
    chk("sb_c3_still_busy", {63'd0, rs1_busy}, 64'd1);
    tick();
    mc_valid = 1'b0;
    #1;
    chk("sb_c4_cleared", {63'd0, rs1_busy}, 64'd0);
    chk("sb_c4_addr", {59'd0, rf_rd_addr}, 64'd7);

    // Scoreboard: issue and complete x9 in the same cycle.
    mc_issue = 1'b1; mc_issue_rd = 5'd9;
    tick();
    mc_issue = 1'b0;
    #1;
    chk("sb9_set", {63'd0, rs2_busy}, 64'd1);
    mc_issue = 1'b1; mc_issue_rd = 5'd9; mc_valid = 1'b1; mc_rd = 5'd9;
    tick();
    mc_issue = 1'b0;
    #1;
    chk("sb9_set_wins", {63'd0, rs2_busy}, 64'd1);
    tick();
    mc_valid = 1'b0;
    #1;
    chk("sb9_cleared", {63'd0, rs2_busy}, 64'd0);

    // Reset the cycle after a grant.
    mc_issue = 1'b1; mc_issue_rd = 5'd12; rs1_addr = 5'd12;
    tick();
    mc_issue = 1'b0;
    #1;
    chk("mid_busy12", {63'd0, rs1_busy}, 64'd1);
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h00000066;
    tick();
    rst = 1'b1; wb_valid = 1'b0;
    #1;
    chk("mid_rst_wb_ready", {63'd0, wb_ready}, 64'd0);
    tick();
    chk("mid_rst_we", {63'd0, rf_we}, 64'd0);
    chk("mid_rst_addr", {59'd0, rf_rd_addr}, 64'd0);
    chk("mid_rst_data", {32'd0, rf_rd_data}, 64'd0);
    chk("mid_rst_busy12", {63'd0, rs1_busy}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_wb_ready", {63'd0, wb_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
